// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : EXE-stage branch resolver; drives fetch redirect, predictor
//            update and a fixed-length wrong-path flush.
// Options  : BRU_PERF_COUNTERS_EN adds saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_E,
  input  logic            stall_E,
  input  logic            is_branch_E,
  input  logic            is_jal_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] rs1_val_E,
  input  logic [XLEN-1:0] rs2_val_E,
  input  logic [XLEN-1:0] pc_E,
  input  logic [XLEN-1:0] imm_E,
  input  logic            pred_taken_E,
  input  logic [XLEN-1:0] pred_target_E,
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PC_Target_E,
  output logic            branch_resolved,
  output logic            actual_taken,
  output logic [XLEN-1:0] branch_pc,
  output logic [XLEN-1:0] branch_target_resolved,
  output logic            flush_DE,
  output logic            busy_flush
`ifdef BRU_PERF_COUNTERS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count,
  output logic [31:0]     flush_cycle_count
`endif
);

  localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic            r_done;

  logic            w_cond;
  logic            w_f3_ok;
  logic            w_elig;
  logic            w_taken;
  logic            w_mispred;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_fall;

  assign w_tgt  = pc_E + imm_E;
  assign w_fall = pc_E + XLEN'(4);

  always_comb begin
    w_cond  = 1'b0;
    w_f3_ok = 1'b1;
    case (funct3_E)
      3'b000:  w_cond = (rs1_val_E == rs2_val_E);
      3'b001:  w_cond = (rs1_val_E != rs2_val_E);
      3'b100:  w_cond = ($signed(rs1_val_E) <  $signed(rs2_val_E));
      3'b101:  w_cond = ($signed(rs1_val_E) >= $signed(rs2_val_E));
      3'b110:  w_cond = (rs1_val_E <  rs2_val_E);
      3'b111:  w_cond = (rs1_val_E >= rs2_val_E);
      default: w_f3_ok = 1'b0;
    endcase
  end

  // Reset gates eligibility so every output is forced low while reset is held.
  assign w_elig = reset & valid_E & ((is_branch_E & w_f3_ok) | is_jal_E)
                & (r_state == S_IDLE) & ~r_done;

  assign w_taken   = is_jal_E | (is_branch_E & w_cond);
  assign w_mispred = w_elig & ((w_taken != pred_taken_E)
                   | (w_taken & pred_taken_E & (pred_target_E != w_tgt)));

  assign branch_resolved        = w_elig;
  assign actual_taken           = w_elig & w_taken;
  assign branch_pc              = w_elig ? pc_E : '0;
  assign branch_target_resolved = w_elig ? w_tgt : '0;
  assign PCSrc_E                = w_mispred;
  assign PC_Target_E            = w_mispred ? (w_taken ? w_tgt : w_fall) : '0;
  assign busy_flush             = (r_state == S_FLUSH);
  assign flush_DE               = w_mispred | busy_flush;

  // The mispredict cycle is the first flush cycle, so FLUSH lasts
  // FLUSH_CYCLES-1 cycles and leaves once the counter is about to reach 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      if (w_elig && stall_E)
        r_done <= 1'b1;
      else if (!stall_E)
        r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_mispred && (FLUSH_CYCLES > 1)) begin
            r_state <= S_FLUSH;
            r_cnt   <= c_flush_load;
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count          <= 32'd0;
      mispred_count     <= 32'd0;
      flush_cycle_count <= 32'd0;
    end else begin
      if (branch_resolved && (br_count != 32'hFFFF_FFFF))
        br_count <= br_count + 32'd1;
      if (PCSrc_E && (mispred_count != 32'hFFFF_FFFF))
        mispred_count <= mispred_count + 32'd1;
      if (flush_DE && (flush_cycle_count != 32'hFFFF_FFFF))
        flush_cycle_count <= flush_cycle_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed scoreboard bench for branch_resolve_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid_E, stall_E, is_branch_E, is_jal_E, pred_taken_E;
  logic [2:0]      funct3_E;
  logic [XLEN-1:0] rs1_val_E, rs2_val_E, pc_E, imm_E, pred_target_E;
  logic            PCSrc_E, branch_resolved, actual_taken, flush_DE, busy_flush;
  logic [XLEN-1:0] PC_Target_E, branch_pc, branch_target_resolved;
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0]     br_count, mispred_count, flush_cycle_count;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .valid_E                (valid_E),
    .stall_E                (stall_E),
    .is_branch_E            (is_branch_E),
    .is_jal_E               (is_jal_E),
    .funct3_E               (funct3_E),
    .rs1_val_E              (rs1_val_E),
    .rs2_val_E              (rs2_val_E),
    .pc_E                   (pc_E),
    .imm_E                  (imm_E),
    .pred_taken_E           (pred_taken_E),
    .pred_target_E          (pred_target_E),
    .PCSrc_E                (PCSrc_E),
    .PC_Target_E            (PC_Target_E),
    .branch_resolved        (branch_resolved),
    .actual_taken           (actual_taken),
    .branch_pc              (branch_pc),
    .branch_target_resolved (branch_target_resolved),
    .flush_DE               (flush_DE),
    .busy_flush             (busy_flush)
`ifdef BRU_PERF_COUNTERS_EN
    ,
    .br_count               (br_count),
    .mispred_count          (mispred_count),
    .flush_cycle_count      (flush_cycle_count)
`endif
  );

  typedef struct packed {
    logic            taken;
    logic            pcsrc;
    logic [XLEN-1:0] pct;
    logic [XLEN-1:0] bpc;
    logic [XLEN-1:0] btr;
  } exp_t;

  exp_t exp_q[$];
  int   flush_q[$];
  int   busy_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   flush_run = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops a record on every update strobe and checks flush run lengths.
  always @(negedge clk) begin
    if (branch_resolved === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: branch_pc %0h, none expected", branch_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("actual_taken", XLEN'(actual_taken), XLEN'(mon_e.taken));
        chk("PCSrc_E", XLEN'(PCSrc_E), XLEN'(mon_e.pcsrc));
        chk("PC_Target_E", PC_Target_E, mon_e.pct);
        chk("branch_pc", branch_pc, mon_e.bpc);
        chk("branch_target_resolved", branch_target_resolved, mon_e.btr);
      end
    end
    if (flush_DE === 1'b1) flush_run++;
    else if (flush_run > 0) begin
      if (flush_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_flush: run %0d, none expected", flush_run);
      end else chk("flush_len", XLEN'(flush_run), XLEN'(flush_q.pop_front()));
      flush_run = 0;
    end
    if (busy_flush === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      if (busy_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_busy: run %0d, none expected", busy_run);
      end else chk("busy_len", XLEN'(busy_run), XLEN'(busy_q.pop_front()));
      busy_run = 0;
    end
  end

  task automatic drive(input logic br, input logic jal, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic pt, input logic [XLEN-1:0] ptg, input logic st);
    valid_E = 1'b1; is_branch_E = br; is_jal_E = jal; funct3_E = f3;
    rs1_val_E = a; rs2_val_E = b; pc_E = pc; imm_E = imm;
    pred_taken_E = pt; pred_target_E = ptg; stall_E = st;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid_E = 1'b0; is_branch_E = 1'b0; is_jal_E = 1'b0; stall_E = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_res(input logic tk, input logic pcs, input logic [XLEN-1:0] pct,
                            input logic [XLEN-1:0] bpc, input logic [XLEN-1:0] btr);
    exp_q.push_back('{tk, pcs, pct, bpc, btr});
  endtask

  task automatic expect_flush(input int f, input int b);
    flush_q.push_back(f);
    if (b > 0) busy_q.push_back(b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_PCSrc_E"}, XLEN'(PCSrc_E), '0);
    chk({tag, "_PC_Target_E"}, PC_Target_E, '0);
    chk({tag, "_branch_resolved"}, XLEN'(branch_resolved), '0);
    chk({tag, "_actual_taken"}, XLEN'(actual_taken), '0);
    chk({tag, "_branch_pc"}, branch_pc, '0);
    chk({tag, "_branch_target_resolved"}, branch_target_resolved, '0);
    chk({tag, "_flush_DE"}, XLEN'(flush_DE), '0);
    chk({tag, "_busy_flush"}, XLEN'(busy_flush), '0);
`ifdef BRU_PERF_COUNTERS_EN
    chk({tag, "_br_count"}, XLEN'(br_count), '0);
    chk({tag, "_mispred_count"}, XLEN'(mispred_count), '0);
    chk({tag, "_flush_cycle_count"}, XLEN'(flush_cycle_count), '0);
`endif
  endtask

  initial begin
    // A live mispredicting branch is presented while reset is held.
    valid_E = 1'b1; stall_E = 1'b0; is_branch_E = 1'b1; is_jal_E = 1'b0;
    funct3_E = 3'b000; rs1_val_E = 64'd3; rs2_val_E = 64'd3; pc_E = 64'h80;
    imm_E = 64'h8; pred_taken_E = 1'b0; pred_target_E = '0;
    #3 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    valid_E = 1'b0; is_branch_E = 1'b0;
    reset = 1'b1;
    idle(1);

    // BEQ taken, correctly predicted
    expect_res(1'b1, 1'b0, 64'h0, 64'h100, 64'h120);
    drive(1'b1, 1'b0, 3'b000, 64'd5, 64'd5, 64'h100, 64'h20, 1'b1, 64'h120, 1'b0);
    idle(1);

    // BNE not taken but predicted taken; a branch during FLUSH is ignored
    expect_res(1'b0, 1'b1, 64'h204, 64'h200, 64'h240);
    expect_flush(2, 1);
    drive(1'b1, 1'b0, 3'b001, 64'd7, 64'd7, 64'h200, 64'h40, 1'b1, 64'h240, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 64'd1, 64'd1, 64'h280, 64'h10, 1'b0, 64'h0, 1'b0);
    idle(2);

    // BLT signed taken vs BLTU unsigned not taken on -1 / 1
    expect_res(1'b1, 1'b1, 64'h50, 64'h40, 64'h50);
    expect_flush(2, 1);
    drive(1'b1, 1'b0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h10, 1'b0, 64'h0, 1'b0);
    idle(1);
    expect_res(1'b0, 1'b0, 64'h0, 64'h40, 64'h50);
    drive(1'b1, 1'b0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h10, 1'b0, 64'h0, 1'b0);
    idle(1);

    // BGE -5 >= -7 taken, mispredicted, held by stall for 3 cycles
    expect_res(1'b1, 1'b1, 64'h308, 64'h300, 64'h308);
    expect_flush(2, 1);
    repeat (3)
      drive(1'b1, 1'b0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF9,
            64'h300, 64'h8, 1'b0, 64'h0, 1'b1);
    drive(1'b1, 1'b0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF9,
          64'h300, 64'h8, 1'b0, 64'h0, 1'b0);
    idle(2);

    // Reserved funct3 010: no strobe, no redirect
    drive(1'b1, 1'b0, 3'b010, 64'd1, 64'd1, 64'h400, 64'h10, 1'b1, 64'h410, 1'b0);
    idle(1);

    // JAL with address wrap
    expect_res(1'b1, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
    expect_flush(2, 1);
    drive(1'b0, 1'b1, 3'b000, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 64'h0, 1'b0);
    idle(2);

    // Direction right, target wrong
    expect_res(1'b1, 1'b1, 64'h640, 64'h600, 64'h640);
    expect_flush(2, 1);
    drive(1'b1, 1'b0, 3'b000, 64'd9, 64'd9, 64'h600, 64'h40, 1'b1, 64'h700, 1'b0);
    idle(2);

`ifdef BRU_PERF_COUNTERS_EN
    chk("br_count_total", XLEN'(br_count), XLEN'(7));
    chk("mispred_count_total", XLEN'(mispred_count), XLEN'(5));
    chk("flush_cycle_count_total", XLEN'(flush_cycle_count), XLEN'(10));
`endif

    // Misprediction, then reset mid-FLUSH with a live branch presented
    expect_res(1'b1, 1'b1, 64'h600, 64'h500, 64'h600);
    expect_flush(1, 0);
    drive(1'b0, 1'b1, 3'b000, 64'd0, 64'd0, 64'h500, 64'h100, 1'b0, 64'h0, 1'b0);
    valid_E = 1'b1; is_branch_E = 1'b1; funct3_E = 3'b000;
    rs1_val_E = 64'd2; rs2_val_E = 64'd2; pred_taken_E = 1'b0;
    #2 reset = 1'b0;
    #1 chk_all_zero("midflush_reset");
    @(posedge clk); #1;
    valid_E = 1'b0; is_branch_E = 1'b0;
    reset = 1'b1;
    idle(3);

    chk("exp_q_drained", XLEN'(exp_q.size()), '0);
    chk("flush_q_drained", XLEN'(flush_q.size()), '0);
    chk("busy_q_drained", XLEN'(busy_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EXE-stage branch resolver: the producing end of the fetch-redirect/predictor-update interface consumed by the IF stage.
- Evaluates conditional branches and JAL against forwarded operands.
- Compares the outcome with the prediction carried down the pipe.
- Drives redirect, predictor-update and flush signals.
- Holds a small flush state machine so wrong-path instructions are squashed for a fixed number of cycles.

Parameters:
XLEN, 64, datapath/address width
FLUSH_CYCLES, 2, cycles flush_DE stays asserted after a redirect (1..7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_E  in  1  EXE slot holds a live instruction
stall_E  in  1  EXE held by HDU this cycle
is_branch_E  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
is_jal_E  in  1  JAL
funct3_E  in  3  branch condition select
rs1_val_E  in  XLEN  forwarded operand 1
rs2_val_E  in  XLEN  forwarded operand 2
pc_E  in  XLEN  PC of the EXE instruction
imm_E  in  XLEN  sign-extended B/J immediate
pred_taken_E  in  1  prediction made at fetch
pred_target_E  in  XLEN  predicted target made at fetch
PCSrc_E  out  1  redirect fetch this cycle
PC_Target_E  out  XLEN  redirect address
branch_resolved  out  1  one-cycle predictor-update strobe
actual_taken  out  1  resolved direction
branch_pc  out  XLEN  PC of the resolved branch
branch_target_resolved  out  XLEN  pc_E + imm_E
flush_DE  out  1  squash IF/ID and ID/EX registers
busy_flush  out  1  flush state machine not idle

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state IDLE; flush counter 0; done flag 0.
- Target: tgt = pc_E + imm_E, modulo 2^XLEN. Fall-through: fall = pc_E + 4, wraps.
- Condition by funct3:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011: not taken, no redirect, no update strobe.
- taken = is_jal_E | (is_branch_E & cond).
- Eligible cycle: valid_E & (is_branch_E | is_jal_E) & state==IDLE & !done.
- Misprediction, in an eligible cycle:
  - (taken != pred_taken_E), or
  - (taken & pred_taken_E & pred_target_E != tgt).
- Combinational outputs in an eligible cycle, zero-latency:
  - branch_resolved=1; actual_taken=taken; branch_pc=pc_E; branch_target_resolved=tgt.
  - On misprediction: PCSrc_E=1; PC_Target_E = taken ? tgt : fall.
  - Not eligible: PCSrc_E=0; PC_Target_E=0; branch_resolved=0; actual_taken=0; branch_pc=0; branch_target_resolved=0.
- done flag: set on an eligible cycle when stall_E=1; cleared on the first cycle with stall_E=0. This gives exactly one update/redirect per instruction even if EXE is held.
- State machine:
  - IDLE -> FLUSH on misprediction; counter loaded with FLUSH_CYCLES-1.
  - FLUSH: decrement each cycle; -> IDLE when counter==0.
  - valid_E is ignored in FLUSH (wrong path).
- flush_DE:
  - Asserted in the misprediction cycle and in every FLUSH cycle: exactly FLUSH_CYCLES consecutive cycles.
  - stall_E does not extend or pause the flush.
- busy_flush = (state==FLUSH).
- Simultaneous events:
  - Misprediction during FLUSH: impossible by gating.
  - Reset mid-FLUSH: returns to IDLE immediately with flush_DE=0.

Optional Feature:
BRU_PERF_COUNTERS_EN
- Defined: adds 32-bit saturating counters, reset to 0, each incrementing on its event:
  - br_count (each branch_resolved)
  - mispred_count (each PCSrc_E)
  - flush_cycle_count (each flush_DE cycle)
- Counters are exposed as extra output ports of the same names.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Test Plan:
1. BEQ, rs1=rs2=5, pc_E=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> branch_resolved=1, actual_taken=1, PCSrc_E=0, flush_DE=0.
2. BNE, rs1=rs2=7, pc_E=0x200, pred_taken=1 -> PCSrc_E=1, PC_Target_E=0x204, flush_DE high for exactly 2 cycles, busy_flush high 1 cycle.
3. BLT rs1=-1, rs2=1 vs BLTU same operands, pc_E=0x40, imm=0x10, pred_taken=0:
   - BLT: taken, PC_Target_E=0x50.
   - BLTU: not taken, PCSrc_E=0.
4. Mispredicted BGE held by stall_E for 3 cycles -> branch_resolved and PCSrc_E pulse once only; flush 2 cycles; a valid branch presented during FLUSH produces no strobe.
5. JAL pc_E=0xFFFF_FFFF_FFFF_FFF0, imm=0x20, pred_taken=0 -> PC_Target_E=0x10 (wrap), PCSrc_E=1.
6. Misprediction, then reset driven low mid-FLUSH -> flush_DE, busy_flush and all outputs 0 at once; with BRU_PERF_COUNTERS_EN, counters read 0.
